object_move_ctl: RTL and testbench

//   Tile-stepped position sequencer for a drawn rectangle (player/enemy sprite).

---
 rtl/object_move_ctl.sv | 190 +++++++++++++++++++
 tb/tb_object_move_ctl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/object_move_ctl.sv
// object_move_ctl
//   Tile-stepped position sequencer for a drawn rectangle. A direction command
//   accepted over dir_valid/dir_ready moves the object one TILE, animated in
//   STEP_PX increments on each rising edge of vblnk_in (frame tick).
//
// Ports
//   clk        pixel clock
//   rst        asynchronous active-high reset
//   vblnk_in   vertical blank; rising edge is the frame tick
//   dir_in     00 up, 01 down, 10 left, 11 right
//   dir_valid  command present on dir_in
//   dir_ready  command accepted when dir_valid & dir_ready at a clk edge
//   x_pos      object left edge (pixels)
//   y_pos      object top edge (pixels)
//   moving     high while a step sequence is in progress
//   blocked    one-cycle pulse when a command fails the bounds check
//
// Optional feature
//   MOVE_QUEUE_EN: one-entry command buffer accepted during MOVE and chained
//   onto the end of the current move without an idle gap.
module object_move_ctl #(
  parameter int unsigned X_INIT  = 0,
  parameter int unsigned Y_INIT  = 0,
  parameter int unsigned TILE    = 60,
  parameter int unsigned STEP_PX = 4,
  parameter int unsigned X_MIN   = 0,
  parameter int unsigned X_MAX   = 740,
  parameter int unsigned Y_MIN   = 0,
  parameter int unsigned Y_MAX   = 540
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic [1:0]  dir_in,
  input  logic        dir_valid,
  output logic        dir_ready,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        moving,
  output logic        blocked
);

  localparam int unsigned      STEPS    = TILE / STEP_PX;
  localparam int unsigned      CNT_W    = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [11:0]      STEP     = 12'(STEP_PX);

  typedef enum logic {IDLE, MOVE} state_t;

  state_t           state_q, state_d;
  logic             vblnk_q;
  logic             tick, accept, last_tick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic [11:0]      x_q, x_d, y_q, y_d;
  logic             blocked_q, blocked_d;
`ifdef MOVE_QUEUE_EN
  logic             qv_q, qv_d;
  logic [1:0]       qdir_q, qdir_d;
  logic [1:0]       next_dir;
`endif

  // Widened to 13 bits so position + TILE cannot wrap.
  function automatic logic out_of_bounds(input logic [1:0] d,
                                         input logic [11:0] x,
                                         input logic [11:0] y);
    logic [12:0] xe;
    logic [12:0] ye;
    logic        r;
    xe = {1'b0, x};
    ye = {1'b0, y};
    case (d)
      2'b00:   r = ye < 13'(Y_MIN + TILE);
      2'b01:   r = (ye + 13'(TILE)) > 13'(Y_MAX);
      2'b10:   r = xe < 13'(X_MIN + TILE);
      default: r = (xe + 13'(TILE)) > 13'(X_MAX);
    endcase
    return r;
  endfunction

  always_comb begin
`ifdef MOVE_QUEUE_EN
    dir_ready = ~rst & ((state_q == IDLE) | ~qv_q);
`else
    dir_ready = ~rst & (state_q == IDLE);
`endif
  end

  assign tick      = vblnk_in & ~vblnk_q;
  assign accept    = dir_valid & dir_ready;
  assign last_tick = tick & (cnt_q == CNT_ONE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    x_d       = x_q;
    y_d       = y_q;
    blocked_d = 1'b0;
`ifdef MOVE_QUEUE_EN
    qv_d      = qv_q;
    qdir_d    = qdir_q;
    next_dir  = qv_q ? qdir_q : dir_in;
`endif
    case (state_q)
      IDLE: begin
        // A tick coinciding with accept is deliberately not used for motion.
        if (accept) begin
          if (out_of_bounds(dir_in, x_q, y_q)) begin
            blocked_d = 1'b1;
          end else begin
            dir_d   = dir_in;
            cnt_d   = CNT_LOAD;
            state_d = MOVE;
          end
        end
      end
      MOVE: begin
        if (tick) begin
          case (dir_q)
            2'b00:   y_d = y_q - STEP;
            2'b01:   y_d = y_q + STEP;
            2'b10:   x_d = x_q - STEP;
            default: x_d = x_q + STEP;
          endcase
          cnt_d = cnt_q - CNT_ONE;
          if (last_tick) begin
            state_d = IDLE;
`ifdef MOVE_QUEUE_EN
            // A command arriving on the final tick with the buffer empty is
            // chained directly rather than dropped.
            if (qv_q | accept) begin
              qv_d = 1'b0;
              if (out_of_bounds(next_dir, x_d, y_d)) begin
                blocked_d = 1'b1;
              end else begin
                dir_d   = next_dir;
                cnt_d   = CNT_LOAD;
                state_d = MOVE;
              end
            end
`endif
          end
        end
`ifdef MOVE_QUEUE_EN
        if (accept && !last_tick) begin
          qv_d   = 1'b1;
          qdir_d = dir_in;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vblnk_q   <= 1'b0;
      cnt_q     <= '0;
      dir_q     <= '0;
      x_q       <= 12'(X_INIT);
      y_q       <= 12'(Y_INIT);
      blocked_q <= 1'b0;
`ifdef MOVE_QUEUE_EN
      qv_q      <= 1'b0;
      qdir_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      vblnk_q   <= vblnk_in;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      x_q       <= x_d;
      y_q       <= y_d;
      blocked_q <= blocked_d;
`ifdef MOVE_QUEUE_EN
      qv_q      <= qv_d;
      qdir_q    <= qdir_d;
`endif
    end
  end

  assign x_pos   = x_q;
  assign y_pos   = y_q;
  assign moving  = (state_q == MOVE);
  assign blocked = blocked_q;

endmodule

// File: tb/tb_object_move_ctl.sv
module tb_object_move_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vblnk_in = 1'b0;
  logic [1:0]  dir_in = 2'b00;
  logic        dir_valid = 1'b0;
  logic        dir_ready;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        moving;
  logic        blocked;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_x    = 0;
  int cur_y    = 0;

  object_move_ctl #(
    .X_INIT(0), .Y_INIT(0), .TILE(60), .STEP_PX(4),
    .X_MIN(0), .X_MAX(740), .Y_MIN(0), .Y_MAX(540)
  ) dut (
    .clk(clk), .rst(rst), .vblnk_in(vblnk_in), .dir_in(dir_in),
    .dir_valid(dir_valid), .dir_ready(dir_ready), .x_pos(x_pos),
    .y_pos(y_pos), .moving(moving), .blocked(blocked)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] dir;
    bit         coincide;
    bit         blk;
    int         ex;
    int         ey;
  } vec_t;

  vec_t vecs [0:15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One frame: rising vblnk edge, random high width, random low gap.
  task automatic frame();
    vblnk_in = 1'b1;
    step();
    repeat ($urandom_range(0, 2)) step();
    vblnk_in = 1'b0;
    repeat ($urandom_range(2, 4)) step();
  endtask

  task automatic send_cmd(input logic [1:0] d, input bit coincide, output bit ok);
    int n = 0;
    dir_in    = d;
    dir_valid = 1'b1;
    while (!dir_ready && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: dir_ready stayed 0 for 2000 cycles, required 1");
      dir_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    if (coincide) vblnk_in = 1'b1;
    step();
    dir_valid = 1'b0;
    vblnk_in  = 1'b0;
    ok = 1'b1;
  endtask

  // Reference rules: plain signed arithmetic on the tile grid.
  function automatic bit model_blocked(input int d, input int x, input int y);
    case (d)
      0:       return (y - 60) < 0;
      1:       return (y + 60) > 540;
      2:       return (x - 60) < 0;
      default: return (x + 60) > 740;
    endcase
  endfunction

  function automatic int model_dx(input int d);
    return (d == 3) ? 1 : ((d == 2) ? -1 : 0);
  endfunction

  function automatic int model_dy(input int d);
    return (d == 1) ? 1 : ((d == 0) ? -1 : 0);
  endfunction

  task automatic run_cmd(input logic [1:0] d, input bit coincide, input bit eblk,
                         input int ex, input int ey);
    bit ok;
    int sx;
    int sy;
    int dxs;
    int dys;
    sx = cur_x;
    sy = cur_y;
    send_cmd(d, coincide, ok);
    if (ok) begin
      chk("blocked_after_accept", 32'(blocked), 32'(eblk));
      chk("moving_after_accept", 32'(moving), 32'(!eblk));
      chk("x_after_accept", 32'(x_pos), sx);
      chk("y_after_accept", 32'(y_pos), sy);
      step();
      chk("blocked_one_cycle", 32'(blocked), 0);
      if (!eblk) begin
        dxs = (ex - sx) / 15;
        dys = (ey - sy) / 15;
        for (int k = 1; k <= 15; k++) begin
          frame();
          chk("x_step", 32'(x_pos), sx + dxs * k);
          chk("y_step", 32'(y_pos), sy + dys * k);
          chk("moving_during", 32'(moving), 32'(k < 15));
        end
      end else begin
        chk("x_blocked_hold", 32'(x_pos), sx);
        chk("y_blocked_hold", 32'(y_pos), sy);
        chk("moving_blocked", 32'(moving), 0);
      end
    end
    cur_x = ex;
    cur_y = ey;
  endtask

  initial begin
    bit ok;
    int d;
    bit eb;
    bit co;

    vecs = '{
      '{2'b11, 1'b0, 1'b0,  60,   0},
      '{2'b01, 1'b1, 1'b0,  60,  60},
      '{2'b10, 1'b0, 1'b0,   0,  60},
      '{2'b10, 1'b0, 1'b1,   0,  60},
      '{2'b00, 1'b0, 1'b0,   0,   0},
      '{2'b00, 1'b1, 1'b1,   0,   0},
      '{2'b01, 1'b0, 1'b0,   0,  60},
      '{2'b01, 1'b0, 1'b0,   0, 120},
      '{2'b01, 1'b0, 1'b0,   0, 180},
      '{2'b01, 1'b0, 1'b0,   0, 240},
      '{2'b01, 1'b0, 1'b0,   0, 300},
      '{2'b01, 1'b0, 1'b0,   0, 360},
      '{2'b01, 1'b0, 1'b0,   0, 420},
      '{2'b01, 1'b0, 1'b0,   0, 480},
      '{2'b01, 1'b0, 1'b0,   0, 540},
      '{2'b01, 1'b0, 1'b1,   0, 540}
    };

    // Asynchronous reset asserted mid-cycle takes effect immediately.
    step();
    step();
    #3 rst = 1'b1;
    #1;
    chk("rst_x", 32'(x_pos), 0);
    chk("rst_y", 32'(y_pos), 0);
    chk("rst_moving", 32'(moving), 0);
    chk("rst_blocked", 32'(blocked), 0);
    chk("rst_ready", 32'(dir_ready), 0);
    step();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(dir_ready), 1);
    step();

    for (int i = 0; i < 16; i++)
      run_cmd(vecs[i].dir, vecs[i].coincide, vecs[i].blk, vecs[i].ex, vecs[i].ey);

    // Right command held valid across the end of the move, from (0,540).
    dir_in    = 2'b11;
    dir_valid = 1'b1;
    chk("held_ready", 32'(dir_ready), 1);
    step();
    chk("held_moving", 32'(moving), 1);
`ifdef MOVE_QUEUE_EN
    chk("held_ready_buf_empty", 32'(dir_ready), 1);
    step();
    dir_valid = 1'b0;
    chk("held_ready_buf_full", 32'(dir_ready), 0);
    for (int k = 1; k <= 30; k++) begin
      frame();
      chk("held_x", 32'(x_pos), 4 * k);
      chk("held_moving_chain", 32'(moving), 32'(k < 30));
    end
`else
    chk("held_ready_in_move", 32'(dir_ready), 0);
    for (int k = 1; k <= 14; k++) begin
      frame();
      chk("held_x", 32'(x_pos), 4 * k);
    end
    vblnk_in = 1'b1;
    step();
    chk("held_x_end1", 32'(x_pos), 60);
    chk("held_moving_drop", 32'(moving), 0);
    chk("held_ready_idle", 32'(dir_ready), 1);
    step();
    chk("held_moving_second", 32'(moving), 1);
    chk("held_blocked_second", 32'(blocked), 0);
    dir_valid = 1'b0;
    vblnk_in  = 1'b0;
    step();
    for (int k = 1; k <= 15; k++) begin
      frame();
      chk("held_x2", 32'(x_pos), 60 + 4 * k);
      chk("held_moving2", 32'(moving), 32'(k < 15));
    end
`endif
    chk("held_y", 32'(y_pos), 540);
    cur_x = 120;
    cur_y = 540;

    // Randomized commands against the grid model.
    for (int i = 0; i < 40; i++) begin
      d  = int'($urandom_range(0, 3));
      co = ($urandom_range(0, 3) == 0);
      eb = model_blocked(d, cur_x, cur_y);
      run_cmd(2'(d), co, eb,
              eb ? cur_x : cur_x + 60 * model_dx(d),
              eb ? cur_y : cur_y + 60 * model_dy(d));
    end

    // Reset in the middle of a move.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    cur_x = 0;
    cur_y = 0;
    send_cmd(2'b11, 1'b0, ok);
    step();
    repeat (7) frame();
    chk("mid_x", 32'(x_pos), 28);
    chk("mid_moving", 32'(moving), 1);
    #3 rst = 1'b1;
    #1;
    chk("midrst_x", 32'(x_pos), 0);
    chk("midrst_y", 32'(y_pos), 0);
    chk("midrst_moving", 32'(moving), 0);
    chk("midrst_ready", 32'(dir_ready), 0);
    step();
    rst = 1'b0;
    step();
    frame();
    chk("after_rst_x", 32'(x_pos), 0);
    chk("after_rst_moving", 32'(moving), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
